// File: rtl/dbg_mem_arbiter.sv
// Arbitrates the core LSU and the debug abstract-memory interface onto one data-memory port.
// Optional debug-access watchdog enabled by defining DBG_MEM_TIMEOUT_EN.
module dbg_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          halted_i,
  input  logic          core_req_i,
  input  logic          core_wr_i,
  input  logic [3:0]    core_st_i,
  input  logic [AW-1:0] core_ad_i,
  input  logic [DW-1:0] core_do_i,
  output logic [DW-1:0] core_di_o,
  output logic          core_done_o,
  input  logic          am_en_i,
  input  logic          am_wr_i,
  input  logic [3:0]    am_st_i,
  input  logic [AW-1:0] am_ad_i,
  input  logic [DW-1:0] am_do_i,
  output logic [DW-1:0] am_di_o,
  output logic          am_done_o,
  output logic          am_err_o,
  output logic          mem_req_o,
  output logic          mem_wr_o,
  output logic [3:0]    mem_st_o,
  output logic [AW-1:0] mem_ad_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CORE_BUSY    = 2'd1,
    DBG_BUSY     = 2'd2,
    DBG_WAIT_LOW = 2'd3
  } state_t;

  state_t state;
  logic   last_dbg;
  logic   dbg_armed;
  logic   dbg_pend;
  logic   core_pend;
  logic   grant_dbg;
  logic   grant_core;
  logic   dbg_timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dbg_mem_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  // DBG_WAIT_LOW arbitrates like IDLE, but only the core may win there.
  always_comb begin
    dbg_pend  = (state == IDLE) && am_en_i && dbg_armed;
    core_pend = ((state == IDLE) || (state == DBG_WAIT_LOW)) && core_req_i;
    if (dbg_pend && core_pend) begin
      grant_dbg = halted_i || !last_dbg;
    end else begin
      grant_dbg = dbg_pend;
    end
    grant_core = core_pend && !grant_dbg;
  end

`ifdef DBG_MEM_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_q;

  // An ack landing on the limit cycle takes precedence over the timeout.
  assign dbg_timeout = (state == DBG_BUSY) && (wd_cnt == 16'(TIMEOUT_CYCLES)) && !mem_ack_i;
  assign am_err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= dbg_timeout;
      if (state != DBG_BUSY) begin
        wd_cnt <= 16'd0;
      end else if (wd_cnt != 16'hFFFF) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= wd_cnt;
      end
    end
  end
`else
  assign dbg_timeout = 1'b0;
  assign am_err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_dbg    <= 1'b0;
      dbg_armed   <= 1'b1;
      mem_req_o   <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_st_o    <= 4'd0;
      mem_ad_o    <= '0;
      mem_wdata_o <= '0;
      core_di_o   <= '0;
      core_done_o <= 1'b0;
      am_di_o     <= '0;
      am_done_o   <= 1'b0;
    end else begin
      core_done_o <= 1'b0;
      am_done_o   <= 1'b0;
      if (!am_en_i) begin
        dbg_armed <= 1'b1;
      end
      case (state)
        IDLE, DBG_WAIT_LOW: begin
          if (grant_dbg) begin
            mem_req_o   <= 1'b1;
            mem_wr_o    <= am_wr_i;
            mem_st_o    <= am_st_i;
            mem_ad_o    <= am_ad_i;
            mem_wdata_o <= am_do_i;
            last_dbg    <= 1'b1;
            state       <= DBG_BUSY;
          end else if (grant_core) begin
            mem_req_o   <= 1'b1;
            mem_wr_o    <= core_wr_i;
            mem_st_o    <= core_st_i;
            mem_ad_o    <= core_ad_i;
            mem_wdata_o <= core_do_i;
            last_dbg    <= 1'b0;
            state       <= CORE_BUSY;
          end else if ((state == DBG_WAIT_LOW) && !am_en_i) begin
            state <= IDLE;
          end else begin
            state <= state;
          end
        end
        CORE_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            core_done_o <= 1'b1;
            state       <= IDLE;
            if (!mem_wr_o) begin
              core_di_o <= mem_rdata_i;
            end
          end
        end
        DBG_BUSY: begin
          if (mem_ack_i || dbg_timeout) begin
            mem_req_o <= 1'b0;
            am_done_o <= 1'b1;
            dbg_armed <= 1'b0;
            state     <= DBG_WAIT_LOW;
            if (!mem_ack_i) begin
              am_di_o <= '0;
            end else if (!mem_wr_o) begin
              am_di_o <= mem_rdata_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Self-checking bench for dbg_mem_arbiter: directed scenarios plus randomized contention
// rounds checked against a transaction-level arbitration model.
module tb_dbg_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    logic          wr;
    logic [3:0]    st;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
  } txn_t;

  logic clk = 1'b0;
  logic rst_i = 1'b0, halted_i = 1'b0;
  logic core_req_i = 1'b0, core_wr_i = 1'b0;
  logic [3:0] core_st_i = 4'd0;
  logic [AW-1:0] core_ad_i = '0;
  logic [DW-1:0] core_do_i = '0, core_di_o;
  logic core_done_o;
  logic am_en_i = 1'b0, am_wr_i = 1'b0;
  logic [3:0] am_st_i = 4'd0;
  logic [AW-1:0] am_ad_i = '0;
  logic [DW-1:0] am_do_i = '0, am_di_o;
  logic am_done_o, am_err_o;
  logic mem_req_o, mem_wr_o;
  logic [3:0] mem_st_o;
  logic [AW-1:0] mem_ad_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic mem_ack_i = 1'b0;

  dbg_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .halted_i(halted_i),
    .core_req_i(core_req_i), .core_wr_i(core_wr_i), .core_st_i(core_st_i),
    .core_ad_i(core_ad_i), .core_do_i(core_do_i), .core_di_o(core_di_o), .core_done_o(core_done_o),
    .am_en_i(am_en_i), .am_wr_i(am_wr_i), .am_st_i(am_st_i), .am_ad_i(am_ad_i), .am_do_i(am_do_i),
    .am_di_o(am_di_o), .am_done_o(am_done_o), .am_err_o(am_err_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_st_o(mem_st_o), .mem_ad_o(mem_ad_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Bench-side memory image and transaction log filled in by serve().
  logic [DW-1:0] mem_img [logic [AW-1:0]];
  txn_t grants[$];
  int core_done_cnt, dbg_done_cnt, err_cnt, overlap, unstable, req_cycles, budget_hit;
  int first_req_cyc, core_done_cyc;
  logic [DW-1:0] core_data, dbg_data;
  int core_len = 1, dbg_len = 1, dbg_hold = 0;
  bit scramble = 0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; core_req_i = 1'b0; am_en_i = 1'b0; mem_ack_i = 1'b0; halted_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Memory responder and requester agent: acks after the side's latency, drops requests on done.
  task automatic serve(input int budget);
    int waited = 0, idle = 0, cyc = 0, hold_left = 0, cur_len = 1;
    logic prev_req = 1'b0;
    logic [31:0] t;
    txn_t cur;
    grants.delete();
    core_done_cnt = 0; dbg_done_cnt = 0; err_cnt = 0; overlap = 0; unstable = 0;
    req_cycles = 0; budget_hit = 0; first_req_cyc = -1; core_done_cyc = -1;
    while (cyc < budget && idle < 2) begin
      @(negedge clk);
      cyc++;
      if (core_done_o && am_done_o) overlap++;
      if (core_done_o) begin
        core_done_cnt++; core_data = core_di_o; core_done_cyc = cyc; core_req_i = 1'b0;
      end
      if (am_done_o) begin
        dbg_done_cnt++; dbg_data = am_di_o;
        if (am_err_o) err_cnt++;
        if (dbg_hold > 0) hold_left = dbg_hold;
        else am_en_i = 1'b0;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) am_en_i = 1'b0;
      end
      if (mem_ack_i) mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (mem_req_o) begin
        if (!prev_req) begin
          cur.wr = mem_wr_o; cur.st = mem_st_o; cur.ad = mem_ad_o; cur.wd = mem_wdata_o;
          grants.push_back(cur);
          waited = 0;
          cur_len = mem_ad_o[31] ? dbg_len : core_len;
          if (first_req_cyc < 0) first_req_cyc = cyc;
          if (scramble) begin
            t = $urandom;
            if (mem_ad_o[31]) begin am_ad_i = {1'b1, t[30:0]}; am_do_i = $urandom; am_wr_i = ~am_wr_i; end
            else begin core_ad_i = {1'b0, t[30:0]}; core_do_i = $urandom; core_wr_i = ~core_wr_i; end
          end
        end else if (mem_wr_o !== cur.wr || mem_st_o !== cur.st || mem_ad_o !== cur.ad || mem_wdata_o !== cur.wd) begin
          unstable++;
        end
        req_cycles++;
        if (waited >= cur_len - 1) begin
          mem_ack_i = 1'b1; mem_rdata_i = mem_rd(mem_ad_o);
        end
        waited++;
      end
      prev_req = mem_req_o;
      if (!core_req_i && !am_en_i && !mem_req_o && !mem_ack_i) idle++;
      else idle = 0;
    end
    if (idle < 2) budget_hit = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1; core_req_i = 1'b1; am_en_i = 1'b1; mem_ack_i = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_req_o, mem_wr_o, mem_st_o, mem_ad_o, mem_wdata_o, core_di_o, core_done_o,
         am_di_o, am_done_o, am_err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b ad=%h cdone=%b adone=%b, required all 0",
               mem_req_o, mem_ad_o, core_done_o, am_done_o);
    end
    core_req_i = 1'b0; am_en_i = 1'b0; mem_ack_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_core_read();
    do_reset();
    mem_img[32'h100] = 32'hDEAD_BEEF;
    core_len = 3; dbg_len = 3; dbg_hold = 0; scramble = 0;
    core_wr_i = 1'b0; core_st_i = 4'hF; core_ad_i = 32'h100; core_do_i = 32'h0;
    core_req_i = 1'b1;
    serve(30);
    n_cmp++;
    if (req_cycles != 3 || first_req_cyc != 1) begin
      n_bad++; $display("FAIL core_read_req: got %0d cycles from cycle %0d, required 3 from 1", req_cycles, first_req_cyc);
    end
    n_cmp++;
    if (core_done_cnt != 1 || core_done_cyc != 4 || core_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL core_read_done: got %0d pulses at %0d data %h, required 1 at 4 data deadbeef",
                        core_done_cnt, core_done_cyc, core_data);
    end
    n_cmp++;
    if (grants.size() != 1 || grants[0].ad !== 32'h100 || grants[0].wr !== 1'b0 || budget_hit != 0) begin
      n_bad++; $display("FAIL core_read_grant: got %0d grants budget_hit=%0d, required one read of 0x100", grants.size(), budget_hit);
    end
  endtask

  task automatic test_priority();
    logic [AW-1:0] first_ad [4];
    logic [AW-1:0] want_ad  [4];
    do_reset();
    core_len = 2; dbg_len = 2; dbg_hold = 0; scramble = 0;
    core_wr_i = 1'b0; core_st_i = 4'hF; core_ad_i = 32'h0000_0200;
    am_wr_i = 1'b0; am_st_i = 4'hF; am_ad_i = 32'h8000_0040;
    // Halted: debug first. Running after reset: debug first. After a lone debug: core first.
    halted_i = 1'b1; core_req_i = 1'b1; am_en_i = 1'b1; serve(40);
    first_ad[0] = grants.size() == 2 ? grants[0].ad : '0; want_ad[0] = 32'h8000_0040;
    do_reset();
    halted_i = 1'b0; core_req_i = 1'b1; am_en_i = 1'b1; serve(40);
    first_ad[1] = grants.size() == 2 ? grants[0].ad : '0; want_ad[1] = 32'h8000_0040;
    am_en_i = 1'b1; serve(40);
    first_ad[2] = grants.size() == 1 ? grants[0].ad : '0; want_ad[2] = 32'h8000_0040;
    core_req_i = 1'b1; am_en_i = 1'b1; serve(40);
    first_ad[3] = grants.size() == 2 ? grants[0].ad : '0; want_ad[3] = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (first_ad[i] !== want_ad[i]) begin
        n_bad++; $display("FAIL priority_%0d: first grant ad=%h, required %h", i, first_ad[i], want_ad[i]);
      end
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    core_len = 2; dbg_len = 2; scramble = 0;
    am_wr_i = 1'b0; am_st_i = 4'hF; am_ad_i = 32'h8000_0080;
    dbg_hold = 10; am_en_i = 1'b1; serve(60);
    n_cmp++;
    if (grants.size() != 1 || dbg_done_cnt != 1) begin
      n_bad++; $display("FAIL level_hold: got %0d accesses %0d dones, required 1 and 1", grants.size(), dbg_done_cnt);
    end
    dbg_hold = 0; am_en_i = 1'b1; serve(30);
    n_cmp++;
    if (grants.size() != 1 || dbg_done_cnt != 1 || dbg_data !== mem_rd(32'h8000_0080)) begin
      n_bad++; $display("FAIL level_rearm: got %0d accesses data %h, required 1 data %h",
                        grants.size(), dbg_data, mem_rd(32'h8000_0080));
    end
  endtask

  task automatic test_dbg_write();
    do_reset();
    core_len = 4; dbg_len = 4; dbg_hold = 0; scramble = 1;
    am_wr_i = 1'b1; am_st_i = 4'h3; am_ad_i = 32'h2000; am_do_i = 32'h1234;
    am_en_i = 1'b1; serve(30);
    n_cmp++;
    if (grants.size() != 1 || grants[0].wr !== 1'b1 || grants[0].st !== 4'h3 ||
        grants[0].ad !== 32'h2000 || grants[0].wd !== 32'h1234) begin
      n_bad++; $display("FAIL dbg_write_fields: got %0d grants wr=%b st=%h ad=%h wd=%h, required 1 1 3 2000 1234",
                        grants.size(), mem_wr_o, mem_st_o, mem_ad_o, mem_wdata_o);
    end
    n_cmp++;
    if (unstable != 0 || req_cycles != 4 || dbg_done_cnt != 1 || err_cnt != 0) begin
      n_bad++; $display("FAIL dbg_write_hold: got unstable=%0d req=%0d done=%0d err=%0d, required 0 4 1 0",
                        unstable, req_cycles, dbg_done_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0, dirty = 0, found = 0;
    do_reset();
    core_wr_i = 1'b0; core_st_i = 4'hF; core_ad_i = 32'h300; core_req_i = 1'b1;
    for (int i = 0; i < 5 && found == 0; i++) begin
      @(negedge clk);
      if (mem_req_o) found = 1;
    end
    n_cmp++;
    if (found != 1) begin
      n_bad++; $display("FAIL reset_mid_req: got no mem_req_o within 5 cycles, required one");
    end
    @(negedge clk);
    rst_i = 1'b1; core_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (core_done_o) seen++;
      if ({mem_req_o, mem_wr_o, mem_st_o, mem_ad_o, mem_wdata_o, core_di_o, am_di_o, am_done_o, am_err_o} !== '0) dirty++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0 || dirty != 0) begin
      n_bad++; $display("FAIL reset_mid: got %0d done pulses %0d nonzero cycles, required 0 and 0", seen, dirty);
    end
  endtask

`ifdef DBG_MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    core_len = 2; dbg_len = 1000; dbg_hold = 0; scramble = 0;
    am_wr_i = 1'b0; am_st_i = 4'hF; am_ad_i = 32'h8000_0100;
    core_wr_i = 1'b0; core_st_i = 4'hF; core_ad_i = 32'h0000_0400;
    halted_i = 1'b1; am_en_i = 1'b1; core_req_i = 1'b1;
    serve(80);
    n_cmp++;
    if (dbg_done_cnt != 1 || err_cnt != 1 || dbg_data !== '0) begin
      n_bad++; $display("FAIL timeout_err: got done=%0d err=%0d data=%h, required 1 1 0", dbg_done_cnt, err_cnt, dbg_data);
    end
    n_cmp++;
    if (req_cycles != TO + 1 + 2 || core_done_cnt != 1 || core_data !== mem_rd(32'h400)) begin
      n_bad++; $display("FAIL timeout_core: got req=%0d core_done=%0d data=%h, required %0d 1 %h",
                        req_cycles, core_done_cnt, core_data, TO + 3, mem_rd(32'h400));
    end
  endtask
`endif

  task automatic test_random();
    txn_t c, d;
    txn_t exp[$];
    logic m_last_dbg = 1'b0;
    logic [DW-1:0] exp_cdi = '0, exp_ddi = '0;
    logic [31:0] t;
    bit wc, wdbg;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      wc = 1'($urandom_range(0, 1)); wdbg = 1'($urandom_range(0, 1));
      if (!wc && !wdbg) wc = 1'b1;
      halted_i = 1'($urandom_range(0, 1));
      c.wr = 1'($urandom_range(0, 1)); c.st = 4'($urandom); t = $urandom; c.ad = {1'b0, t[30:0]}; c.wd = $urandom;
      d.wr = 1'($urandom_range(0, 1)); d.st = 4'($urandom); t = $urandom; d.ad = {1'b1, t[30:0]}; d.wd = $urandom;
      core_wr_i = c.wr; core_st_i = c.st; core_ad_i = c.ad; core_do_i = c.wd;
      am_wr_i = d.wr; am_st_i = d.st; am_ad_i = d.ad; am_do_i = d.wd;
      // Model: halted or core-last -> debug first; the loser goes next and becomes the last grant.
      exp.delete();
      if (wc && wdbg) begin
        if (halted_i || !m_last_dbg) begin exp.push_back(d); exp.push_back(c); m_last_dbg = 1'b0; end
        else begin exp.push_back(c); exp.push_back(d); m_last_dbg = 1'b1; end
      end else if (wdbg) begin
        exp.push_back(d); m_last_dbg = 1'b1;
      end else begin
        exp.push_back(c); m_last_dbg = 1'b0;
      end
      if (wc && !c.wr) exp_cdi = mem_rd(c.ad);
      if (wdbg && !d.wr) exp_ddi = mem_rd(d.ad);
      core_len = $urandom_range(1, 4); dbg_len = $urandom_range(1, 4);
      dbg_hold = $urandom_range(0, 3); scramble = 1;
      core_req_i = wc; am_en_i = wdbg;
      serve(80);
      n_cmp++;
      if (grants.size() != exp.size()) begin
        n_bad++; $display("FAIL rand_%0d_count: got %0d grants, required %0d", r, grants.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_cmp++;
          if (grants[i].ad !== exp[i].ad || grants[i].wr !== exp[i].wr ||
              grants[i].st !== exp[i].st || grants[i].wd !== exp[i].wd) begin
            n_bad++; $display("FAIL rand_%0d_grant%0d: got ad=%h wr=%b st=%h wd=%h, required ad=%h wr=%b st=%h wd=%h",
                              r, i, grants[i].ad, grants[i].wr, grants[i].st, grants[i].wd,
                              exp[i].ad, exp[i].wr, exp[i].st, exp[i].wd);
          end
        end
      end
      n_cmp++;
      if (core_done_cnt != int'(wc) || dbg_done_cnt != int'(wdbg) || err_cnt != 0 ||
          core_di_o !== exp_cdi || am_di_o !== exp_ddi) begin
        n_bad++; $display("FAIL rand_%0d_done: got cdone=%0d ddone=%0d err=%0d cdi=%h adi=%h, required %0d %0d 0 %h %h",
                          r, core_done_cnt, dbg_done_cnt, err_cnt, core_di_o, am_di_o, wc, wdbg, exp_cdi, exp_ddi);
      end
      n_cmp++;
      if (overlap != 0 || unstable != 0 || budget_hit != 0) begin
        n_bad++; $display("FAIL rand_%0d_proto: got overlap=%0d unstable=%0d budget_hit=%0d, required 0 0 0",
                          r, overlap, unstable, budget_hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_priority();
    test_level_hold();
    test_dbg_write();
    test_reset_mid();
`ifdef DBG_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_mem_arbiter.md
Name: dbg_mem_arbiter

Overview:
- Shares the core's single data-memory port between the core load/store unit and the debug module's abstract-memory interface.
- Sequences each access as one in-order transaction.
- Gives the debug side priority while the hart is halted and alternates grants while running, so neither side starves.
- Sits between the dm memory-access outputs, the core LSU and the memory/bus adapter, all in the core clock domain.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT_CYCLES, 255, debug-access watchdog limit in cycles; used only with DBG_MEM_TIMEOUT_EN; legal range 1..65535

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset: synchronous, active-high; one clock (clk_i)
halted_i  in  1  hart halted status
core_req_i  in  1  core request; level, held until core_done_o
core_wr_i  in  1  core write (1) / read (0)
core_st_i  in  4  core byte strobes
core_ad_i  in  AW  core address
core_do_i  in  DW  core write data
core_di_o  out  DW  core read data
core_done_o  out  1  core completion pulse
am_en_i  in  1  debug request; level, held until am_done_o
am_wr_i  in  1  debug write (1) / read (0)
am_st_i  in  4  debug byte strobes
am_ad_i  in  AW  debug address
am_do_i  in  DW  debug write data
am_di_o  out  DW  debug read data
am_done_o  out  1  debug completion pulse
am_err_o  out  1  debug access error, valid with am_done_o
mem_req_o  out  1  memory request; held until mem_ack_i
mem_wr_o  out  1  memory write
mem_st_o  out  4  memory byte strobes
mem_ad_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_rdata_i  in  DW  memory read data, valid with mem_ack_i
mem_ack_i  in  1  single-cycle memory acknowledge

Behaviour:
- Reset: all outputs 0, FSM=IDLE, last_grant=CORE, dbg_armed=1, watchdog counter=0. Reset takes effect mid-transaction:
  - any pending done pulse is discarded;
  - mem_ack_i arriving after reset is ignored.
- FSM states: IDLE, CORE_BUSY, DBG_BUSY, DBG_WAIT_LOW.
- IDLE, request sampling:
  - dbg_pend = am_en_i & dbg_armed.
  - core_pend = core_req_i.
- IDLE, arbitration when both are pending:
  - halted_i=1: debug wins.
  - halted_i=0: grant the side not in last_grant.
  - A single pending side wins immediately.
- On grant: register the winner's wr/st/ad/wdata onto mem_*, set mem_req_o=1 in the next cycle, and update last_grant.
- Latency: request sampled in IDLE at cycle N gives mem_req_o=1 at N+1. mem_req_o and all mem_* fields stay stable until mem_ack_i.
- CORE_BUSY:
  - On mem_ack_i at cycle M: mem_req_o=0 at M+1, core_di_o=mem_rdata_i for reads (writes leave core_di_o unchanged), core_done_o=1 for exactly cycle M+1.
  - Return to IDLE. A new grant can be sampled at M+1, giving mem_req_o at M+2.
- DBG_BUSY: same completion timing on am_di_o/am_done_o with am_err_o=0. Then go to DBG_WAIT_LOW with dbg_armed=0.
- DBG_WAIT_LOW:
  - Transparent to core arbitration: it behaves as IDLE with dbg_pend forced 0.
  - dbg_armed returns to 1 once am_en_i is sampled 0.
  - A level held high after done never causes a duplicate access.
- mem_ack_i in IDLE is ignored. No pipelining: at most one outstanding transaction.
- Request inputs changing while their side is not granted are don't-care. Inputs of the granted side are not re-sampled after grant.
- Done pulses never coincide: at most one of core_done_o/am_done_o is high per cycle.

Optional Feature:
DBG_MEM_TIMEOUT_EN:
- Defined: a counter runs in DBG_BUSY from 0. When it reaches TIMEOUT_CYCLES with no mem_ack_i:
  - next cycle: mem_req_o=0, am_done_o=1, am_err_o=1, am_di_o=0;
  - FSM goes to DBG_WAIT_LOW.
  - A mem_ack_i in the same cycle as the limit wins: normal completion, am_err_o=0.
- Core transactions are never timed out.
- Not defined: no counter, am_err_o tied 0, and a debug access waits indefinitely for mem_ack_i.

Test Plan:
1. Core read only, ad=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_req_o high 3 cycles; core_di_o=0xDEADBEEF with a one-cycle core_done_o.
2. Both requests pending in IDLE, halted_i=1 -> debug transaction first (mem_ad_o=am_ad_i), then core. Same with halted_i=0 and last_grant=CORE -> debug first; repeated contention alternates.
3. am_en_i held high for 10 cycles after am_done_o -> exactly one memory access. Drop am_en_i, reassert -> second access occurs.
4. Debug write st=0x3, ad=0x2000, do=0x1234 -> mem_wr_o=1, mem_st_o=0x3, mem_wdata_o=0x1234 stable until ack.
5. rst_i asserted while mem_req_o=1 in CORE_BUSY, ack arrives after reset -> no core_done_o; all outputs 0.
6. DBG_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> am_done_o=1, am_err_o=1 after the limit, mem_req_o dropped; core request then served normally.
